feature_map_readback: RTL

//  Capture side of the CNN output stream. Collects each frame's valid-qualified
//    2-channel results (linear layer, 36 positions) into an on-chip buffer.

---
 rtl/feature_map_readback.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/feature_map_readback.sv
// Captures one frame of channel pairs, then returns it one byte per rd_next with 1-cycle latency.
// No backpressure: in_valid while the frame is held is dropped and flagged sticky; ARGMAX_EN adds per-channel max tracking.
module feature_map_readback #(
    parameter int NUM_POS = 36,
    parameter int DATA_W  = 8,
    parameter int PTR_W   = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data_0,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic              in_valid,
    input  logic              rd_next,
    input  logic              clr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              frame_done,
    output logic              overflow,
    output logic [5:0]        wr_count,
    output logic [DATA_W-1:0] max_val_0,
    output logic [DATA_W-1:0] max_val_1,
    output logic [5:0]        max_idx_0,
    output logic [5:0]        max_idx_1
);

    localparam int CNT_W = 6;
    localparam logic [0:0]       ST_CAPTURE = 1'b0;
    localparam logic [0:0]       ST_READY   = 1'b1;
    localparam logic [CNT_W-1:0] LAST_PAIR  = CNT_W'(NUM_POS - 1);
    localparam logic [PTR_W-1:0] LAST_BYTE  = PTR_W'(2 * NUM_POS - 1);

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_wr_count;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_rd_last;
    logic              r_frame_done;
    logic              r_overflow;

    // One word per pair keeps a single write port; byte select comes from rd_ptr[0].
    logic [2*DATA_W-1:0] r_mem [NUM_POS];

    logic                w_capture;
    logic                w_read;
    logic                w_last;
    logic [2*DATA_W-1:0] w_rd_pair;
    logic [DATA_W-1:0]   w_rd_byte;

    assign w_capture = (r_state == ST_CAPTURE) && in_valid;
    assign w_read    = (r_state == ST_READY) && rd_next;
    assign w_last    = w_read && (r_rd_ptr == LAST_BYTE);
    assign w_rd_pair = r_mem[r_rd_ptr[PTR_W-1:1]];
    assign w_rd_byte = r_rd_ptr[0] ? w_rd_pair[2*DATA_W-1:DATA_W] : w_rd_pair[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (w_capture && !reset && !clr) begin
            r_mem[r_wr_count] <= {in_data_1, in_data_0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_CAPTURE;
            r_wr_count   <= '0;
            r_rd_ptr     <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (clr) begin
            r_state      <= ST_CAPTURE;
            r_wr_count   <= '0;
            r_rd_ptr     <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            case (r_state)
                ST_CAPTURE: begin
                    if (in_valid) begin
                        r_wr_count <= r_wr_count + CNT_W'(1);
                        if (r_wr_count == LAST_PAIR) begin
                            r_state      <= ST_READY;
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    if (in_valid) begin
                        r_overflow <= 1'b1;
                    end
                    if (rd_next) begin
                        r_rd_data  <= w_rd_byte;
                        r_rd_valid <= 1'b1;
                        r_rd_last  <= w_last;
                        if (w_last) begin
                            r_rd_ptr     <= '0;
                            r_wr_count   <= '0;
                            r_frame_done <= 1'b0;
                            r_state      <= ST_CAPTURE;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                        end
                    end
                end
                default: r_state <= ST_CAPTURE;
            endcase
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign rd_last    = r_rd_last;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign wr_count   = r_wr_count;

`ifdef ARGMAX_EN
    logic [DATA_W-1:0] r_max_val_0;
    logic [DATA_W-1:0] r_max_val_1;
    logic [CNT_W-1:0]  r_max_idx_0;
    logic [CNT_W-1:0]  r_max_idx_1;

    // Strict compare so ties keep the earliest position; cleared when the frame is released.
    always_ff @(posedge clk) begin
        if (reset || clr || w_last) begin
            r_max_val_0 <= '0;
            r_max_val_1 <= '0;
            r_max_idx_0 <= '0;
            r_max_idx_1 <= '0;
        end else if (w_capture) begin
            if (in_data_0 > r_max_val_0) begin
                r_max_val_0 <= in_data_0;
                r_max_idx_0 <= r_wr_count;
            end
            if (in_data_1 > r_max_val_1) begin
                r_max_val_1 <= in_data_1;
                r_max_idx_1 <= r_wr_count;
            end
        end
    end

    assign max_val_0 = r_max_val_0;
    assign max_val_1 = r_max_val_1;
    assign max_idx_0 = r_max_idx_0;
    assign max_idx_1 = r_max_idx_1;
`else
    assign max_val_0 = '0;
    assign max_val_1 = '0;
    assign max_idx_0 = '0;
    assign max_idx_1 = '0;
`endif

endmodule
